// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - compare codes, op kinds and FSM states for branch_resolve_ctrl
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_NE  = 3'd1;
    localparam logic [2:0] CMP_LT  = 3'd4;
    localparam logic [2:0] CMP_GE  = 3'd5;
    localparam logic [2:0] CMP_LTU = 3'd6;
    localparam logic [2:0] CMP_GEU = 3'd7;

    localparam logic [1:0] BRK_BR   = 2'd0;
    localparam logic [1:0] BRK_JAL  = 2'd1;
    localparam logic [1:0] BRK_JALR = 2'd2;

    typedef enum logic [1:0] {
        BRS_IDLE     = 2'd0,
        BRS_WAIT_OPS = 2'd1,
        BRS_RESOLVE  = 2'd2,
        BRS_REDIRECT = 2'd3
    } brs_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_br_target_calc.sv
// rtl/branch_resolve_ctrl_br_target_calc.sv - br_target_calc: target, fall-through pc and misalignment flag
module br_target_calc
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      kind,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    logic [XLEN-1:0] base_sum;

    // All sums wrap modulo 2^XLEN; JALR drops bit 0 after the add.
    always_comb begin
        base_sum = ((kind == BRK_JALR) ? rs1 : pc) + imm;
        target   = base_sum;
        if (kind == BRK_JALR) begin
            target[0] = 1'b0;
        end
        pc_plus4 = pc + XLEN'(4);
        misalign = |target[1:0];
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - EX-stage branch resolution FSM with redirect handshake; optional BR_STATS_EN counters
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_cmp,
    input  logic [1:0]      in_kind,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_tgt,
    input  logic            ops_ready,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            kill,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush_pulse,
    output logic            misalign_exc,
    output logic            res_valid,
    output logic            res_taken
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_br_cnt,
    output logic [CNT_W-1:0] stat_mis_cnt
`endif
);

    brs_state_t      state;
    logic [2:0]      op_cmp;
    logic [1:0]      op_kind;
    logic [XLEN-1:0] op_pc;
    logic [XLEN-1:0] op_imm;
    logic            op_pred_taken;
    logic [XLEN-1:0] op_pred_tgt;

    logic            res_taken_q;
    logic            res_mis_q;
    logic            res_redir_q;

    logic            cmp_true;
    logic            taken_c;
    logic [XLEN-1:0] tgt_c;
    logic [XLEN-1:0] pc4_c;
    logic            tgt_mis_c;
    logic            misalign_c;
    logic            mispredict_c;
    logic [XLEN-1:0] next_pc_c;

    // Outcome is evaluated from the live forwarded operands in the ops_ready cycle
    // and registered, so RESOLVE drives its pulses straight from flops.
    always_comb begin
        cmp_true = 1'b0;
        case (op_cmp)
            CMP_EQ:  cmp_true = (rs1_val == rs2_val);
            CMP_NE:  cmp_true = (rs1_val != rs2_val);
            CMP_LT:  cmp_true = ($signed(rs1_val) <  $signed(rs2_val));
            CMP_GE:  cmp_true = ($signed(rs1_val) >= $signed(rs2_val));
            CMP_LTU: cmp_true = (rs1_val <  rs2_val);
            CMP_GEU: cmp_true = (rs1_val >= rs2_val);
            default: cmp_true = 1'b0;
        endcase
    end

    br_target_calc #(
        .XLEN(XLEN)
    ) u_target_calc (
        .pc       (op_pc),
        .rs1      (rs1_val),
        .imm      (op_imm),
        .kind     (op_kind),
        .target   (tgt_c),
        .pc_plus4 (pc4_c),
        .misalign (tgt_mis_c)
    );

    always_comb begin
        taken_c      = (op_kind == BRK_BR) ? cmp_true : 1'b1;
        misalign_c   = taken_c & tgt_mis_c;
        mispredict_c = (taken_c != op_pred_taken) | (taken_c & (tgt_c != op_pred_tgt));
        next_pc_c    = taken_c ? tgt_c : pc4_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= BRS_IDLE;
            op_cmp        <= '0;
            op_kind       <= '0;
            op_pc         <= '0;
            op_imm        <= '0;
            op_pred_taken <= 1'b0;
            op_pred_tgt   <= '0;
            res_taken_q   <= 1'b0;
            res_mis_q     <= 1'b0;
            res_redir_q   <= 1'b0;
            redir_pc      <= '0;
        end else if (kill) begin
            state <= BRS_IDLE;
        end else begin
            case (state)
                BRS_IDLE: begin
                    if (in_valid) begin
                        op_cmp        <= in_cmp;
                        op_kind       <= in_kind;
                        op_pc         <= in_pc;
                        op_imm        <= in_imm;
                        op_pred_taken <= in_pred_taken;
                        op_pred_tgt   <= in_pred_tgt;
                        state         <= BRS_WAIT_OPS;
                    end
                end
                BRS_WAIT_OPS: begin
                    if (ops_ready) begin
                        res_taken_q <= taken_c;
                        res_mis_q   <= misalign_c;
                        // A misaligned target is handed to the exception path, never redirected here.
                        res_redir_q <= mispredict_c & ~misalign_c;
                        redir_pc    <= next_pc_c;
                        state       <= BRS_RESOLVE;
                    end
                end
                BRS_RESOLVE: begin
                    state <= res_redir_q ? BRS_REDIRECT : BRS_IDLE;
                end
                BRS_REDIRECT: begin
                    if (redir_ready) begin
                        state <= BRS_IDLE;
                    end
                end
                default: state <= BRS_IDLE;
            endcase
        end
    end

    // kill suppresses every pulse and the redirect in the same cycle.
    always_comb begin
        in_ready     = (state == BRS_IDLE) & ~kill;
        res_valid    = (state == BRS_RESOLVE) & ~kill;
        res_taken    = res_valid & res_taken_q;
        misalign_exc = res_valid & res_mis_q;
        redir_valid  = (state == BRS_REDIRECT) & ~kill;
        flush_pulse  = redir_valid & redir_ready;
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_cnt  <= '0;
            stat_mis_cnt <= '0;
        end else begin
            if (res_valid && (stat_br_cnt != '1)) begin
                stat_br_cnt <= stat_br_cnt + 1'b1;
            end
            if (res_valid && res_redir_q && (stat_mis_cnt != '1)) begin
                stat_mis_cnt <= stat_mis_cnt + 1'b1;
            end
        end
    end
`else
    logic [CNT_W-1:0] stat_unused;
    assign stat_unused = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - randomized and directed bench for branch_resolve_ctrl with a behavioural model
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_cmp;
    logic [1:0]  in_kind;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic [31:0] in_pred_tgt;
    logic        ops_ready;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        kill;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush_pulse;
    logic        misalign_exc;
    logic        res_valid;
    logic        res_taken;
`ifdef BR_STATS_EN
    logic [31:0] stat_br_cnt;
    logic [31:0] stat_mis_cnt;
`endif

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cmp        (in_cmp),
        .in_kind       (in_kind),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .in_pred_taken (in_pred_taken),
        .in_pred_tgt   (in_pred_tgt),
        .ops_ready     (ops_ready),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .kill          (kill),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flush_pulse   (flush_pulse),
        .misalign_exc  (misalign_exc),
        .res_valid     (res_valid),
        .res_taken     (res_taken)
`ifdef BR_STATS_EN
        ,
        .stat_br_cnt   (stat_br_cnt),
        .stat_mis_cnt  (stat_mis_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0]  cmp;
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } op_t;

    int n_chk = 0;
    int n_fail = 0;
    int exp_br = 0;
    int exp_mis = 0;

    logic        chk_en = 1'b0;
    logic        e_ir, e_ir_chk, e_rv, e_rt, e_me, e_dv, e_fl, e_pc_chk;
    logic [31:0] e_dpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Outcome of one op computed straight from the resolution rules.
    function automatic void model(input op_t o, output logic tk, output logic [31:0] tg,
                                  output logic [31:0] nx, output logic mp, output logic ma);
        logic c;
        case (o.cmp)
            3'd0: c = (o.rs1 == o.rs2);
            3'd1: c = (o.rs1 != o.rs2);
            3'd4: c = ($signed(o.rs1) <  $signed(o.rs2));
            3'd5: c = ($signed(o.rs1) >= $signed(o.rs2));
            3'd6: c = (o.rs1 <  o.rs2);
            3'd7: c = (o.rs1 >= o.rs2);
            default: c = 1'b0;
        endcase
        tk = (o.kind == BRK_BR) ? c : 1'b1;
        tg = (o.kind == BRK_JALR) ? ((o.rs1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
        nx = tk ? tg : o.pc + 32'd4;
        mp = (tk != o.pt) || (tk && (tg != o.ptgt));
        ma = tk && (tg % 4 != 0);
    endfunction

    function automatic op_t mk(input logic [2:0] c, input logic [1:0] k, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                               input logic pt, input logic [31:0] ptgt);
        op_t o;
        o.cmp = c; o.kind = k; o.pc = pc; o.imm = imm;
        o.rs1 = a; o.rs2 = b; o.pt = pt; o.ptgt = ptgt;
        return o;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_ir_chk) chk("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
            chk("res_valid", {31'd0, res_valid}, {31'd0, e_rv});
            chk("res_taken", {31'd0, res_taken}, {31'd0, e_rt});
            chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, e_me});
            chk("redir_valid", {31'd0, redir_valid}, {31'd0, e_dv});
            chk("flush_pulse", {31'd0, flush_pulse}, {31'd0, e_fl});
            if (e_dv || e_pc_chk) chk("redir_pc", redir_pc, e_dpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet(input logic idle);
        e_ir = idle; e_ir_chk = ~kill; e_rv = 0; e_rt = 0; e_me = 0;
        e_dv = 0; e_fl = 0; e_pc_chk = 0; e_dpc = 32'd0;
    endtask

    task automatic exp_reset();
        exp_quiet(1'b1);
        e_pc_chk = 1'b1;
        exp_br = 0;
        exp_mis = 0;
    endtask

    // Cycle after a reset edge: reset still asserted, outputs must show reset values.
    task automatic reset_tail();
        kill = 1'b0; ops_ready = 1'b0; in_valid = 1'b0; redir_ready = 1'b0;
        chk_en = 1'b1;
        exp_reset();
        tick();
        rst_n = 1'b1;
        exp_quiet(1'b1);
    endtask

    // kp: 0 none, 1 kill on ops cycle, 2 kill in RESOLVE, 3 kill in REDIRECT step kidx,
    //     4 kill alongside in_valid in IDLE, 5 reset mid-WAIT_OPS, 6 reset in REDIRECT step kidx.
    task automatic run_op(input op_t o, input int nwait, input int rdy_wait, input int kp, input int kidx);
        logic tk, mp, ma, redir;
        logic [31:0] tg, nx;
        model(o, tk, tg, nx, mp, ma);
        redir = mp && !ma;

        in_valid = 1'b1; in_cmp = o.cmp; in_kind = o.kind; in_pc = o.pc; in_imm = o.imm;
        in_pred_taken = o.pt; in_pred_tgt = o.ptgt;
        ops_ready = 1'($urandom_range(0, 1)); redir_ready = 1'($urandom_range(0, 1));
        kill = (kp == 4);
        exp_quiet(1'b1);
        tick();
        if (kp == 4) begin
            kill = 1'b0;
            exp_quiet(1'b1);
            tick();
        end
        in_valid = 1'b0; in_pc = $urandom; in_imm = $urandom; in_cmp = 3'($urandom);
        in_kind = 2'($urandom); in_pred_tgt = $urandom; in_pred_taken = 1'($urandom);

        for (int i = 0; i < nwait; i++) begin
            ops_ready = 1'b0; rs1_val = $urandom; rs2_val = $urandom;
            redir_ready = 1'($urandom_range(0, 1));
            exp_quiet(1'b0);
            tick();
        end

        ops_ready = 1'b1; rs1_val = o.rs1; rs2_val = o.rs2;
        redir_ready = 1'($urandom_range(0, 1));
        kill = (kp == 1);
        exp_quiet(1'b0);
        if (kp == 5) begin
            rst_n = 1'b0; kill = 1'b1; chk_en = 1'b0;
        end
        tick();
        ops_ready = 1'b0; rs1_val = $urandom; rs2_val = $urandom;
        if (kp == 5) begin
            reset_tail();
            return;
        end
        if (kp == 1) begin
            kill = 1'b0;
            exp_quiet(1'b1);
            return;
        end

        kill = (kp == 2);
        redir_ready = 1'($urandom_range(0, 1));
        exp_quiet(1'b0);
        if (!kill) begin
            e_rv = 1'b1; e_rt = tk; e_me = ma;
            exp_br++;
            if (redir) exp_mis++;
        end
        tick();
        if (kp == 2 || !redir) begin
            kill = 1'b0; redir_ready = 1'b0;
            exp_quiet(1'b1);
            return;
        end

        for (int j = 0; j <= rdy_wait; j++) begin
            redir_ready = (j == rdy_wait);
            kill = (kp == 3 && j == kidx);
            exp_quiet(1'b0);
            e_dv = ~kill; e_dpc = nx; e_fl = redir_ready & ~kill;
            if (kp == 6 && j == kidx) begin
                rst_n = 1'b0; chk_en = 1'b0;
            end
            tick();
            if (kp == 6 && j == kidx) begin
                reset_tail();
                return;
            end
            if (kill || redir_ready) break;
        end
        kill = 1'b0; redir_ready = 1'b0;
        exp_quiet(1'b1);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; ops_ready = 1'($urandom_range(0, 1));
            redir_ready = 1'($urandom_range(0, 1)); kill = ($urandom_range(0, 3) == 0);
            exp_quiet(1'b1);
            tick();
        end
        kill = 1'b0;
        exp_quiet(1'b1);
    endtask

    function automatic op_t rand_op();
        op_t o;
        logic tk, mp, ma;
        logic [31:0] tg, nx;
        o.kind = 2'($urandom_range(0, 2));
        o.cmp  = 3'($urandom_range(0, 7));
        o.pc   = $urandom & 32'hFFFF_FFFC;
        o.imm  = (32'($urandom_range(0, 255)) - 32'd128) << 2;
        if ($urandom_range(0, 7) == 0) o.imm = o.imm + 32'd2;
        o.rs1  = $urandom;
        if (o.kind == BRK_JALR && $urandom_range(0, 3) != 0) o.rs1 = o.rs1 & 32'hFFFF_FFFC;
        o.rs2  = ($urandom_range(0, 2) == 0) ? o.rs1 : $urandom;
        o.pt   = 1'b0; o.ptgt = 32'd0;
        model(o, tk, tg, nx, mp, ma);
        if ($urandom_range(0, 2) != 0) begin
            o.pt = tk; o.ptgt = tk ? tg : $urandom;
        end else begin
            o.pt = 1'($urandom_range(0, 1));
            o.ptgt = ($urandom_range(0, 1) == 1) ? tg : $urandom;
        end
        return o;
    endfunction

    initial begin
        op_t o;
        logic tk, mp, ma;
        logic [31:0] tg, nx;
        int kp, rw, kidx;

        rst_n = 1'b0; in_valid = 1'b0; in_cmp = '0; in_kind = '0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_tgt = '0; ops_ready = 1'b0; rs1_val = '0; rs2_val = '0;
        kill = 1'b0; redir_ready = 1'b0;
        exp_quiet(1'b1);
        tick();
        tick();
        reset_tail();

        o = mk(CMP_EQ, BRK_BR, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0);
        model(o, tk, tg, nx, mp, ma);
        chk("pin_beq_taken", {31'd0, tk}, 32'd1);
        chk("pin_beq_next", nx, 32'h120);
        chk("pin_beq_mispredict", {31'd0, mp}, 32'd1);
        run_op(o, 0, 2, 0, 0);

        o = mk(CMP_LT, BRK_BR, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h240);
        model(o, tk, tg, nx, mp, ma);
        chk("pin_blt_taken", {31'd0, tk}, 32'd1);
        chk("pin_blt_mispredict", {31'd0, mp}, 32'd0);
        run_op(o, 0, 0, 0, 0);

        o = mk(CMP_LTU, BRK_BR, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        model(o, tk, tg, nx, mp, ma);
        chk("pin_bltu_taken", {31'd0, tk}, 32'd0);
        chk("pin_bltu_next", nx, 32'h204);
        run_op(o, 0, 0, 0, 0);

        o = mk(CMP_EQ, BRK_JALR, 32'h300, 32'd0, 32'h2003, 32'd0, 1'b1, 32'h1000);
        model(o, tk, tg, nx, mp, ma);
        chk("pin_jalr_target", tg, 32'h2002);
        chk("pin_jalr_misalign", {31'd0, ma}, 32'd1);
        run_op(o, 0, 0, 0, 0);
`ifdef BR_STATS_EN
        chk("stat_br_cnt_4", stat_br_cnt, 32'd4);
        chk("stat_mis_cnt_1", stat_mis_cnt, 32'd1);
`endif

        o = mk(CMP_EQ, BRK_JAL, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 1'b1, 32'd0);
        model(o, tk, tg, nx, mp, ma);
        chk("pin_jal_wrap", nx, 32'h10);
        run_op(o, 1, 1, 0, 0);

        o = mk(3'd2, BRK_BR, 32'h600, 32'h40, 32'd5, 32'd5, 1'b1, 32'h640);
        model(o, tk, tg, nx, mp, ma);
        chk("pin_unknown_cmp", {31'd0, tk}, 32'd0);
        run_op(o, 0, 0, 0, 0);

        run_op(mk(CMP_NE, BRK_BR, 32'h400, 32'h8, 32'd1, 32'd2, 1'b1, 32'h408), 3, 0, 0, 0);
        run_op(mk(CMP_GEU, BRK_BR, 32'h500, 32'h10, 32'd3, 32'd3, 1'b0, 32'd0), 0, 5, 3, 2);
        run_op(mk(CMP_GEU, BRK_BR, 32'h500, 32'h10, 32'd3, 32'd3, 1'b0, 32'd0), 0, 2, 3, 2);
        run_op(mk(CMP_EQ, BRK_BR, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0), 2, 0, 5, 0);
        run_op(mk(CMP_EQ, BRK_BR, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0), 0, 3, 6, 1);
        run_op(mk(CMP_LT, BRK_BR, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0), 0, 0, 4, 0);
        run_op(mk(CMP_EQ, BRK_BR, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0), 0, 0, 2, 0);
        run_op(mk(CMP_EQ, BRK_BR, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0), 1, 0, 1, 0);

        for (int n = 0; n < 300; n++) begin
            o = rand_op();
            rw = $urandom_range(0, 3);
            kidx = $urandom_range(0, rw);
            case ($urandom_range(0, 11))
                7: kp = 1;
                8: kp = 2;
                9: kp = 3;
                10: kp = 4;
                11: kp = ($urandom_range(0, 1) == 1) ? 5 : 6;
                default: kp = 0;
            endcase
            run_op(o, $urandom_range(0, 3), rw, kp, kidx);
            idle_gap($urandom_range(0, 2));
        end

`ifdef BR_STATS_EN
        chk("stat_br_cnt_end", stat_br_cnt, 32'(exp_br));
        chk("stat_mis_cnt_end", stat_mis_cnt, 32'(exp_mis));
`endif
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
